// File: rtl/lsu_mem_initiator_if.sv
// Request/response handshake and data-memory bus between the execute stage,
// the load/store unit and the memory decoder.
interface lsu_mem_initiator_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Load/store unit: word-only memory bus, byte/half stores via read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to report misaligned/illegal requests via resp_err.
module lsu_mem_initiator #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic                 CLK,
    input logic                 RESET,
    lsu_mem_initiator_if.master bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_p0;
    logic              we_p0;
    logic [2:0]        funct3_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [DATA_W-1:0] rdata_p1;
    logic              err_p0;
    logic              accept;
    logic              illegal;
    logic              err_in;
    logic [2:0]        funct3_in;

    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                      input logic [1:0] a,
                                                      input logic [2:0] f3);
        logic signed [7:0]        b_s;
        logic signed [15:0]       h_s;
        logic signed [DATA_W-1:0] ext;
        b_s = word[{a, 3'b000} +: 8];
        h_s = word[{a[1], 4'b0000} +: 16];
        case (f3[1:0])
            2'b00:   ext = f3[2] ? {{(DATA_W-8){1'b0}}, b_s} : {{(DATA_W-8){b_s[7]}}, b_s};
            2'b01:   ext = f3[2] ? {{(DATA_W-16){1'b0}}, h_s} : {{(DATA_W-16){h_s[15]}}, h_s};
            default: ext = word;
        endcase
        return ext;
    endfunction

    function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] word,
                                                      input logic [DATA_W-1:0] wdata,
                                                      input logic [1:0] a,
                                                      input logic [2:0] f3);
        logic [DATA_W-1:0] m;
        m = word;
        case (f3[1:0])
            2'b00:   m[{a, 3'b000} +: 8] = wdata[7:0];
            2'b01:   m[{a[1], 4'b0000} +: 16] = wdata[15:0];
            default: m = wdata;
        endcase
        return m;
    endfunction

    assign accept = (state == IDLE) && bus.req_valid;

    // Loads reject 011/110/111; stores reject anything outside sb/sh/sw.
    always_comb begin
        illegal = 1'b0;
        if (bus.req_we)
            illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
        else
            illegal = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'b110);
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign  = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    assign err_in    = illegal || misalign;
    assign funct3_in = bus.req_funct3;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)       err_p0 <= 1'b0;
        else if (accept) err_p0 <= err_in;
    end
`else
    // Without trapping, misaligned word/half accesses fall onto the enclosing
    // aligned unit naturally because extraction only looks at the lane bits.
    assign err_in    = 1'b0;
    assign funct3_in = illegal ? 3'b010 : bus.req_funct3;
    assign err_p0    = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            addr_p0   <= '0;
            we_p0     <= 1'b0;
            funct3_p0 <= 3'b000;
            wdata_p0  <= '0;
            rdata_p1  <= '0;
        end else begin
            if (accept) begin
                addr_p0   <= bus.req_addr;
                we_p0     <= bus.req_we;
                funct3_p0 <= funct3_in;
                wdata_p0  <= bus.req_wdata;
            end
            // RD cycle: capture the addressed word for load extraction or merge
            if (state == RD) rdata_p1 <= bus.mem_rdata;
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = '0;
        bus.mem_addr   = '0;
        bus.mem_we     = 1'b0;
        bus.mem_wdata  = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (err_in)                                     state_nxt = RESP;
                    else if (bus.req_we && (funct3_in[1:0] == 2'b10)) state_nxt = WR;
                    else                                            state_nxt = RD;
                end
            end
            RD: begin
                bus.mem_addr = {addr_p0[ADDR_W-1:2], 2'b00};
                state_nxt    = we_p0 ? WR : RESP;
            end
            WR: begin
                bus.mem_addr  = {addr_p0[ADDR_W-1:2], 2'b00};
                bus.mem_we    = 1'b1;
                bus.mem_wdata = store_merge(rdata_p1, wdata_p0, addr_p0[1:0], funct3_p0);
                state_nxt     = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_p0;
                if (!we_p0 && !err_p0)
                    bus.resp_rdata = load_extend(rdata_p1, addr_p0[1:0], funct3_p0);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator with a small word memory model.
module tb_lsu_mem_initiator;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    lsu_mem_initiator_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lsu_mem_initiator #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus.master)
    );

    // Word memory at 0x800..0x83F; word 0x800 preloaded while reset is held at an edge.
    logic [31:0] mem [0:15];
    assign bus.mem_rdata = mem[bus.mem_addr[5:2]];
    always @(posedge CLK) begin
        if (RESET)           mem[0] <= 32'h8765F0A1;
        else if (bus.mem_we) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        int n = 0;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata;
        while (!bus.req_ready && n < 10) begin @(negedge CLK); n++; end
        vectors++;
        if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL accept_ready: got %b want 1", bus.req_ready); end
        @(posedge CLK);
        @(negedge CLK);
        bus.req_valid = 1'b0;
    endtask

    // Starts at the first sample point after the accept edge (lat 1).
    task automatic wait_resp(output logic [31:0] rd, output logic er, output int lat,
                             output int wec, output int wecyc, output logic [31:0] wa,
                             output logic [31:0] wd, output logic [31:0] a1);
        lat = 1; wec = 0; wecyc = 0; wa = '0; wd = '0; rd = '0; er = 1'b0;
        a1 = bus.mem_addr;
        forever begin
            if (bus.mem_we) begin wec++; wecyc = lat; wa = bus.mem_addr; wd = bus.mem_wdata; end
            if (bus.resp_valid) begin rd = bus.resp_rdata; er = bus.resp_err; break; end
            if (lat >= 8) begin lat = 99; break; end
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
        vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
        vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
        vectors++; if (bus.mem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
        vectors++; if ({bus.resp_rdata, bus.resp_err} !== 33'h0) begin miscompares++; $display("FAIL rst_resp: got %h/%b want 0/0", bus.resp_rdata, bus.resp_err); end
        RESET = 1'b0;
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adrs [4] = '{32'h800, 32'h800, 32'h802, 32'h802};
        logic [31:0] want [4] = '{32'hFFFFFFA1, 32'h000000A1, 32'hFFFF8765, 32'h00008765};
        logic [31:0] rd, wa, wd, a1;
        logic er; int lat, wec, wecyc; exp_t e;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{want[i], 1'b0, 2});
            issue(1'b0, f3s[i], adrs[i], 32'h0);
            wait_resp(rd, er, lat, wec, wecyc, wa, wd, a1);
            e = sb_q.pop_front();
            vectors++; if (rd !== e.rdata) begin miscompares++; $display("FAIL load%0d_rdata: got %h want %h", i, rd, e.rdata); end
            vectors++; if (er !== e.err) begin miscompares++; $display("FAIL load%0d_err: got %b want %b", i, er, e.err); end
            vectors++; if (lat != e.lat) begin miscompares++; $display("FAIL load%0d_latency: got %0d want %0d", i, lat, e.lat); end
            vectors++; if (wec != 0) begin miscompares++; $display("FAIL load%0d_mem_we: got %0d strobes want 0", i, wec); end
            vectors++; if (a1 !== 32'h800) begin miscompares++; $display("FAIL load%0d_rd_addr: got %h want 800", i, a1); end
        end
    endtask

    task automatic test_sb_then_lw();
        logic [31:0] rd, wa, wd, a1;
        logic er; int lat, wec, wecyc; exp_t e;
        sb_q.push_back('{32'h0, 1'b0, 3});
        issue(1'b1, 3'b000, 32'h801, 32'hDEADBE3C);
        wait_resp(rd, er, lat, wec, wecyc, wa, wd, a1);
        e = sb_q.pop_front();
        vectors++; if (a1 !== 32'h800) begin miscompares++; $display("FAIL sb_rd_addr: got %h want 800", a1); end
        vectors++; if (wec != 1 || wecyc != 2) begin miscompares++; $display("FAIL sb_we_timing: got %0d strobes at %0d want 1 at 2", wec, wecyc); end
        vectors++; if (wd !== 32'h87653CA1) begin miscompares++; $display("FAIL sb_wdata: got %h want 87653ca1", wd); end
        vectors++; if (wa !== 32'h800) begin miscompares++; $display("FAIL sb_waddr: got %h want 800", wa); end
        vectors++; if (lat != e.lat || rd !== e.rdata) begin miscompares++; $display("FAIL sb_resp: got lat %0d rdata %h want %0d %h", lat, rd, e.lat, e.rdata); end
        sb_q.push_back('{32'h87653CA1, 1'b0, 2});
        issue(1'b0, 3'b010, 32'h800, 32'h0);
        wait_resp(rd, er, lat, wec, wecyc, wa, wd, a1);
        e = sb_q.pop_front();
        vectors++; if (rd !== e.rdata || lat != e.lat) begin miscompares++; $display("FAIL lw_after_sb: got %h lat %0d want %h lat %0d", rd, lat, e.rdata, e.lat); end
    endtask

    task automatic test_sw();
        logic [31:0] rd, wa, wd, a1;
        logic er; int lat, wec, wecyc; exp_t e;
        sb_q.push_back('{32'h0, 1'b0, 2});
        issue(1'b1, 3'b010, 32'h804, 32'h12345678);
        wait_resp(rd, er, lat, wec, wecyc, wa, wd, a1);
        e = sb_q.pop_front();
        vectors++; if (wec != 1 || wecyc != 1) begin miscompares++; $display("FAIL sw_we_timing: got %0d strobes at %0d want 1 at 1", wec, wecyc); end
        vectors++; if (wa !== 32'h804 || wd !== 32'h12345678) begin miscompares++; $display("FAIL sw_bus: got %h/%h want 804/12345678", wa, wd); end
        vectors++; if (lat != e.lat || rd !== e.rdata || er !== e.err) begin miscompares++; $display("FAIL sw_resp: got lat %0d rdata %h err %b want %0d %h %b", lat, rd, er, e.lat, e.rdata, e.err); end
        vectors++; if (mem[1] !== 32'h12345678) begin miscompares++; $display("FAIL sw_mem: got %h want 12345678", mem[1]); end
    endtask

    task automatic test_misalign();
        logic        wes  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3s  [4] = '{3'b010, 3'b001, 3'b011, 3'b111};
        logic [31:0] adrs [4] = '{32'h802, 32'h803, 32'h800, 32'h808};
`ifdef LSU_MISALIGN_TRAP_EN
        logic [31:0] want [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
        logic        werr [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        int          wlat [4] = '{1, 1, 1, 1};
        int          wwec [4] = '{0, 0, 0, 0};
`else
        logic [31:0] want [4] = '{32'h87653CA1, 32'hFFFF8765, 32'h87653CA1, 32'h0};
        logic        werr [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
        int          wlat [4] = '{2, 2, 2, 2};
        int          wwec [4] = '{0, 0, 0, 1};
`endif
        logic [31:0] rd, wa, wd, a1;
        logic er; int lat, wec, wecyc; exp_t e;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{want[i], werr[i], wlat[i]});
            issue(wes[i], f3s[i], adrs[i], 32'hA5A5A5A5);
            wait_resp(rd, er, lat, wec, wecyc, wa, wd, a1);
            e = sb_q.pop_front();
            vectors++; if (rd !== e.rdata || er !== e.err) begin miscompares++; $display("FAIL mis%0d_resp: got %h err %b want %h err %b", i, rd, er, e.rdata, e.err); end
            vectors++; if (lat != e.lat) begin miscompares++; $display("FAIL mis%0d_latency: got %0d want %0d", i, lat, e.lat); end
            vectors++; if (wec != wwec[i]) begin miscompares++; $display("FAIL mis%0d_mem_we: got %0d strobes want %0d", i, wec, wwec[i]); end
        end
`ifndef LSU_MISALIGN_TRAP_EN
        vectors++; if (wa !== 32'h808 || wd !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL mis_store_as_sw: got %h/%h want 808/a5a5a5a5", wa, wd); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3s  [3] = '{3'b010, 3'b100, 3'b001};
        logic [31:0] adrs [3] = '{32'h800, 32'h803, 32'h800};
        logic [31:0] want [3] = '{32'h87653CA1, 32'h00000087, 32'h00003CA1};
        int acc [3]; int rsp [3];
        int got = 0; int t = 0; int n;
        exp_t e;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = f3s[i];
                    bus.req_addr = adrs[i]; bus.req_wdata = 32'h0;
                    n = 0;
                    while (!bus.req_ready && n < 20) begin @(negedge CLK); n++; end
                    sb_q.push_back('{want[i], 1'b0, 2});
                    @(posedge CLK);
                    @(negedge CLK);
                    acc[i] = cyc;
                end
                bus.req_valid = 1'b0;
            end
            begin
                while (got < 3 && t < 40) begin
                    @(negedge CLK);
                    t++;
                    if (bus.resp_valid) begin
                        vectors++;
                        if (sb_q.size() == 0) begin
                            miscompares++; $display("FAIL b2b_spurious: got response with empty scoreboard want none");
                        end else begin
                            e = sb_q.pop_front();
                            if (bus.resp_rdata !== e.rdata) begin miscompares++; $display("FAIL b2b%0d_rdata: got %h want %h", got, bus.resp_rdata, e.rdata); end
                        end
                        rsp[got] = cyc;
                        got++;
                    end
                end
            end
        join
        vectors++; if (got != 3) begin miscompares++; $display("FAIL b2b_count: got %0d responses want 3", got); end
        for (int i = 1; i < 3; i++) begin
            vectors++; if (acc[i] - acc[i-1] != 3) begin miscompares++; $display("FAIL b2b%0d_gap: got %0d want 3", i, acc[i] - acc[i-1]); end
        end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (got == 3 && rsp[i] - acc[i] + 1 != 2) begin miscompares++; $display("FAIL b2b%0d_latency: got %0d want 2", i, rsp[i] - acc[i] + 1); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, wa, wd, a1;
        logic er; int lat, wec, wecyc; exp_t e;
        issue(1'b1, 3'b001, 32'h806, 32'h0000BEEF);
        vectors++; if (bus.mem_addr !== 32'h804 || bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL rmid_rd: got %h/%b want 804/0", bus.mem_addr, bus.mem_we); end
        @(posedge CLK);
        #2;
        vectors++; if (bus.mem_we !== 1'b1) begin miscompares++; $display("FAIL rmid_in_wr: got %b want 1", bus.mem_we); end
        RESET = 1'b1;
        #1;
        vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL rmid_we_drop: got %b want 0", bus.mem_we); end
        vectors++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_idle: got ready %b valid %b want 1 0", bus.req_ready, bus.resp_valid); end
        @(negedge CLK);
        RESET = 1'b0;
        vectors++; if (mem[1] !== 32'h12345678) begin miscompares++; $display("FAIL rmid_no_write: got %h want 12345678", mem[1]); end
        sb_q.push_back('{32'h0, 1'b0, 3});
        issue(1'b1, 3'b001, 32'h806, 32'h0000BEEF);
        wait_resp(rd, er, lat, wec, wecyc, wa, wd, a1);
        e = sb_q.pop_front();
        vectors++; if (wd !== 32'hBEEF5678 || wa !== 32'h804) begin miscompares++; $display("FAIL rmid_sh_bus: got %h/%h want 804/beef5678", wa, wd); end
        vectors++; if (lat != e.lat || rd !== e.rdata) begin miscompares++; $display("FAIL rmid_sh_resp: got lat %0d rdata %h want %0d %h", lat, rd, e.lat, e.rdata); end
        sb_q.push_back('{32'hBEEF5678, 1'b0, 2});
        issue(1'b0, 3'b010, 32'h804, 32'h0);
        wait_resp(rd, er, lat, wec, wecyc, wa, wd, a1);
        e = sb_q.pop_front();
        vectors++; if (rd !== e.rdata || lat != e.lat) begin miscompares++; $display("FAIL rmid_lw: got %h lat %0d want %h lat %0d", rd, lat, e.rdata, e.lat); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        test_reset();
        test_loads();
        test_sb_then_lw();
        test_sw();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store unit on the core side of the data-memory bus; it initiates every data access.
- Accepts one load/store request at a time from the execute stage, using RV32I funct3 encoding.
- Drives a word-aligned address, single-bit write enable and write data toward the memory decoder. Reads return combinationally in the same cycle.
- Builds byte/halfword stores by read-modify-write, so memory only ever sees full-word writes. Extracts and sign/zero-extends load data.

Parameters:
- ADDR_W, 32, address width of request and memory ports.
- DATA_W, 32, data width; fixed at 32 (byte lanes assume 4 bytes).

Ports:
- CLK  input  1  single clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  000 b, 001 h, 010 w, 100 bu, 101 hu (loads); 000/001/010 (stores).
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  store data; low byte/half used for sb/sh.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  DATA_W  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned access (valid with resp_valid).
- mem_addr  output  ADDR_W  {req_addr[ADDR_W-1:2],2'b00}; 0 when idle.
- mem_we  output  1  full-word write strobe.
- mem_wdata  output  DATA_W  word to write.
- mem_rdata  input  DATA_W  combinational read data for mem_addr.

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - req_ready=1; all other outputs 0.
  - Internal addr, funct3, wdata and rdata registers cleared.
  - mem_we falls immediately on RESET assertion.
- States: IDLE, RD, WR, RESP. Outputs are decoded from registered state and registers only.
- Accept: req_valid && req_ready at edge k. The unit latches addr, we, funct3 and wdata. req_valid is ignored outside IDLE.
- Alignment: h/hu need addr[0]==0; w needs addr[1:0]==00; b/bu are always aligned. Illegal funct3 (011, 110, 111; stores with 1xx) counts as error.
- IDLE -> RESP on error. No memory cycle; resp_err=1, resp_rdata=0.
- IDLE -> RD for loads and for sb/sh.
- IDLE -> WR for sw.
- RD: mem_addr valid; mem_rdata registered at the end of the cycle.
  - Load: RD -> RESP.
  - sb/sh: RD -> WR.
- WR:
  - mem_we=1 for exactly one cycle; WR -> RESP.
  - sw: mem_wdata = wdata.
  - sb: mem_wdata = captured word with lane addr[1:0] replaced by wdata[7:0].
  - sh: mem_wdata = captured word with half addr[1] replaced by wdata[15:0].
- RESP: resp_valid=1 for one cycle, then RESP -> IDLE. req_ready returns the following cycle.
- Load extraction (little-endian):
  - Byte = word[8*addr[1:0] +: 8]; half = word[16*addr[1] +: 16].
  - b/h sign-extend; bu/hu zero-extend; w passes through.
- Latency, from accept edge k to the cycle resp_valid is high:
  - Load: 2 cycles.
  - sw: 2 cycles.
  - sb/sh: 3 cycles.
  - Error: 1 cycle.
- Back-to-back: the minimum gap between accepts is latency+1 cycles. The unit never overlaps two requests.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: behaviour as above; misaligned and illegal requests give resp_err=1 with no memory access.
- Undefined:
  - resp_err is tied to 0.
  - Misaligned h/w accesses use addr[0] forced 0 (h) or addr[1:0] forced 00 (w) and proceed normally.
  - Illegal funct3 on loads is treated as w; illegal funct3 on stores is treated as sw.

Test Plan:
- Memory word 0x800 = 0x8765F0A1.
  - lb 0x800 -> resp_rdata 0xFFFFFFA1.
  - lbu 0x800 -> 0x000000A1.
  - lh 0x802 -> 0xFFFF8765.
  - lhu 0x802 -> 0x00008765.
  - Each response arrives 2 cycles after accept, with mem_we=0 throughout.
- sb 0x801, wdata 0xDEADBE3C, on word 0x8765F0A1 -> RD at k+1, mem_we=1 with mem_wdata 0x87653CA1 at k+2, resp_valid at k+3. A following lw 0x800 returns 0x87653CA1.
- sw 0x804, wdata 0x12345678 -> no RD cycle; mem_we=1 at k+1 with mem_addr 0x804; resp_valid at k+2 with rdata 0.
- lw 0x802 (trap enabled) -> resp_valid at k+1, resp_err=1, rdata 0, mem_we never asserted. With the macro undefined -> reads 0x800, resp_err=0.
- req_valid held high continuously with three loads -> accepts only when req_ready=1, one every 3 cycles, responses in order.
- RESET asserted mid-cycle during WR of an sh -> mem_we drops immediately and the unit is in IDLE with req_ready=1. The next request completes normally.
